// File: rtl/emac_host_arbiter_if.sv
// rtl/emac_host_arbiter_if.sv - requester and EMAC host-port bundle for emac_host_arbiter
interface emac_host_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_i;
  logic [2*NUM_REQ-1:0]  opcode_i;
  logic [NUM_REQ-1:0]    miimsel_i;
  logic [10*NUM_REQ-1:0] addr_i;
  logic [32*NUM_REQ-1:0] wrdata_i;
  logic [NUM_REQ-1:0]    done_o;
  logic                  err_o;
  logic [31:0]           rddata_o;
  logic                  busy_o;

  logic                  hostclk;
  logic                  hostreq;
  logic                  hostmiimsel;
  logic [1:0]            hostopcode;
  logic [9:0]            hostaddr;
  logic [31:0]           hostwrdata;
  logic [31:0]           hostrddata;
  logic                  hostmiimrdy;

  modport master (
    input  req_i, opcode_i, miimsel_i, addr_i, wrdata_i, hostrddata, hostmiimrdy,
    output done_o, err_o, rddata_o, busy_o,
           hostclk, hostreq, hostmiimsel, hostopcode, hostaddr, hostwrdata
  );

  modport slave (
    output req_i, opcode_i, miimsel_i, addr_i, wrdata_i, hostrddata, hostmiimrdy,
    input  done_o, err_o, rddata_o, busy_o,
           hostclk, hostreq, hostmiimsel, hostopcode, hostaddr, hostwrdata
  );
endinterface

// File: rtl/emac_host_arbiter.sv
// rtl/emac_host_arbiter.sv - round-robin arbiter sharing the EMAC host-management port
// One requester owns the port per op; MDIO ops wait on miimrdy with a timeout, config ops are fixed-length.
module emac_host_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int TIMEOUT_W = 24
) (
  input logic                 wb_clk_i,
  input logic                 wb_rst_n_i,
  emac_host_arbiter_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MDIO    = 3'd1;
  localparam logic [2:0] ST_CFG_WR  = 3'd2;
  localparam logic [2:0] ST_CFG_RD0 = 3'd3;
  localparam logic [2:0] ST_CFG_RD1 = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  logic [2:0]           state;
  logic [IDX_W-1:0]     last;
  logic [IDX_W-1:0]     winner;
  logic [IDX_W-1:0]     pick;
  logic [IDX_W-1:0]     cand;
  logic                 found;
  logic [TIMEOUT_W-1:0] timeout;
  logic [TIMEOUT_W-1:0] timeout_nxt;
  logic                 sel_miimsel;
  logic [1:0]           sel_opcode;
  logic [9:0]           sel_addr;
  logic [31:0]          sel_wrdata;
  logic [NUM_REQ-1:0]   winner_onehot;

  assign bus.hostclk = wb_clk_i;
  assign timeout_nxt = timeout + 1'b1;

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last) + i) % NUM_REQ);
      if (!found && bus.req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    sel_miimsel   = 1'b1;
    sel_opcode    = '0;
    sel_addr      = '0;
    sel_wrdata    = '0;
    winner_onehot = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (pick == IDX_W'(j)) begin
        sel_miimsel = bus.miimsel_i[j];
        sel_opcode  = bus.opcode_i[2*j +: 2];
        sel_addr    = bus.addr_i[10*j +: 10];
        sel_wrdata  = bus.wrdata_i[32*j +: 32];
      end
      winner_onehot[j] = (winner == IDX_W'(j));
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state           <= ST_IDLE;
      last            <= IDX_W'(NUM_REQ - 1);
      winner          <= '0;
      timeout         <= '0;
      bus.hostreq     <= 1'b0;
      bus.hostmiimsel <= 1'b1;
      bus.hostopcode  <= '0;
      bus.hostaddr    <= '0;
      bus.hostwrdata  <= '0;
      bus.rddata_o    <= '0;
      bus.done_o      <= '0;
      bus.err_o       <= 1'b0;
      bus.busy_o      <= 1'b0;
    end else begin
      bus.hostreq <= 1'b0;
      bus.done_o  <= '0;
      bus.err_o   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            winner         <= pick;
            timeout        <= '0;
            bus.hostopcode <= sel_opcode;
            bus.hostaddr   <= sel_addr;
            bus.hostwrdata <= sel_wrdata;
            bus.busy_o     <= 1'b1;
            if (sel_miimsel) begin
              state           <= ST_MDIO;
              bus.hostreq     <= 1'b1;
              bus.hostmiimsel <= 1'b1;
            end else begin
              bus.hostmiimsel <= 1'b0;
              state           <= sel_opcode[1] ? ST_CFG_RD0 : ST_CFG_WR;
            end
          end
        end
        ST_MDIO: begin
          timeout <= timeout_nxt;
          // miimrdy in the request cycle still reflects the previous op, so it is ignored.
          if (!bus.hostreq && bus.hostmiimrdy) begin
            bus.rddata_o <= bus.hostrddata;
            bus.done_o   <= winner_onehot;
            state        <= ST_DONE;
          end else if (timeout_nxt == '1) begin
            bus.rddata_o <= '1;
            bus.err_o    <= 1'b1;
            bus.done_o   <= winner_onehot;
            state        <= ST_DONE;
          end
        end
        ST_CFG_WR: begin
          bus.hostmiimsel <= 1'b1;
          bus.done_o      <= winner_onehot;
          state           <= ST_DONE;
        end
        ST_CFG_RD0: begin
          state <= ST_CFG_RD1;
        end
        ST_CFG_RD1: begin
          bus.rddata_o    <= bus.hostrddata;
          bus.hostmiimsel <= 1'b1;
          bus.done_o      <= winner_onehot;
          state           <= ST_DONE;
        end
        ST_DONE: begin
          last       <= winner;
          bus.busy_o <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          bus.hostmiimsel <= 1'b1;
          bus.busy_o      <= 1'b0;
          state           <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_emac_host_arbiter.sv
// tb/tb_emac_host_arbiter.sv - scoreboard bench for emac_host_arbiter
module tb_emac_host_arbiter;
  localparam int NUM_REQ = 2;
  localparam int TW      = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  emac_host_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

  emac_host_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_W(TW)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus)
  );

  typedef struct {
    logic [1:0]  done;
    logic        err;
    logic [31:0] rddata;
    logic [9:0]  addr;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_rd   = '0;

  logic        phy_stuck = 1'b0;
  int          phy_delay = 0;
  int          phy_cnt   = 0;
  logic        phy_armed = 1'b0;
  logic [31:0] phy_data  = '0;
  logic [31:0] cfg_data  = '0;

  int lat, msel_lo, req_hi, idle;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard: every done_o pulse must match the oldest queued op.
  always @(negedge clk) begin
    if (rst_n && bus.done_o != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(bus.done_o), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_vec", 64'(bus.done_o), 64'(mon_e.done));
        check("err",      64'(bus.err_o),  64'(mon_e.err));
        check("rddata",   64'(bus.rddata_o), 64'(mon_e.rddata));
        check("hostaddr", 64'(bus.hostaddr), 64'(mon_e.addr));
      end
    end
  end

  // EMAC model: stale ready/garbage in the request cycle, then ready after phy_delay low cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      phy_armed = 1'b0;
      bus.hostmiimrdy = 1'b0;
    end else if (bus.hostreq) begin
      phy_armed = 1'b1;
      phy_cnt = phy_delay;
      bus.hostmiimrdy = !phy_stuck;
      bus.hostrddata = 32'hDEAD_BEEF;
    end else if (phy_armed && bus.done_o != '0) begin
      phy_armed = 1'b0;
      bus.hostmiimrdy = 1'b0;
    end else if (phy_armed) begin
      if (phy_stuck || phy_cnt > 0) begin
        bus.hostmiimrdy = 1'b0;
        if (phy_cnt > 0) phy_cnt--;
      end else begin
        bus.hostmiimrdy = 1'b1;
        bus.hostrddata = phy_data;
      end
    end else begin
      bus.hostmiimrdy = 1'b0;
      bus.hostrddata = cfg_data;
    end
  end

  task automatic drive(input int idx, input logic miim, input logic [1:0] op,
                       input logic [9:0] addr, input logic [31:0] data);
    bus.miimsel_i[idx]        = miim;
    bus.opcode_i[2*idx +: 2]  = op;
    bus.addr_i[10*idx +: 10]  = addr;
    bus.wrdata_i[32*idx +: 32] = data;
    bus.req_i[idx]            = 1'b1;
  endtask

  task automatic wait_done(output int l, output int ml, output int rh, output int id);
    l = 0; ml = 0; rh = 0; id = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      l++;
      @(negedge clk);
      if (bus.hostreq) rh++;
      if (!bus.hostmiimsel) ml++;
      if (!bus.busy_o) id++;
      if (bus.done_o != '0) return;
    end
    check("done_within_bound", 64'd0, 64'd1);
  endtask

  initial begin
    bus.req_i     = '0;
    bus.opcode_i  = '0;
    bus.miimsel_i = '0;
    bus.addr_i    = '0;
    bus.wrdata_i  = '0;
    bus.hostrddata  = '0;
    bus.hostmiimrdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",        64'(bus.busy_o), 64'd0);
    check("rst_hostreq",     64'(bus.hostreq), 64'd0);
    check("rst_hostmiimsel", 64'(bus.hostmiimsel), 64'd1);
    check("rst_done",        64'(bus.done_o), 64'd0);
    check("rst_err",         64'(bus.err_o), 64'd0);
    check("rst_rddata",      64'(bus.rddata_o), 64'd0);
    check("rst_hostaddr",    64'(bus.hostaddr), 64'd0);
    check("rst_hostwrdata",  64'(bus.hostwrdata), 64'd0);
    check("rst_hostclk",     64'(bus.hostclk), 64'(clk));
    rst_n = 1'b1;
    @(negedge clk);

    // Config write from requester 0.
    sb.push_back('{2'b01, 1'b0, exp_rd, 10'h240});
    drive(0, 1'b0, 2'b00, 10'h240, 32'h1234_5678);
    wait_done(lat, msel_lo, req_hi, idle);
    bus.req_i = '0;
    check("wr_latency",    64'(lat), 64'd2);
    check("wr_miimsel_lo", 64'(msel_lo), 64'd1);
    check("wr_hostreq",    64'(req_hi), 64'd0);
    check("wr_hostwrdata", 64'(bus.hostwrdata), 64'h1234_5678);
    check("wr_hostopcode", 64'(bus.hostopcode), 64'd0);
    @(negedge clk);

    // Config read from requester 1.
    cfg_data = 32'hCAFE_0001;
    exp_rd   = 32'hCAFE_0001;
    sb.push_back('{2'b10, 1'b0, exp_rd, 10'h0A5});
    drive(1, 1'b0, 2'b10, 10'h0A5, 32'h0);
    wait_done(lat, msel_lo, req_hi, idle);
    bus.req_i = '0;
    check("rd_latency",    64'(lat), 64'd3);
    check("rd_miimsel_lo", 64'(msel_lo), 64'd2);
    check("rd_hostopcode", 64'(bus.hostopcode), 64'd2);
    @(negedge clk);

    // Both requesters held high: four back-to-back writes alternate 0,1,0,1.
    drive(0, 1'b0, 2'b00, 10'h100, 32'h0000_00A0);
    drive(1, 1'b0, 2'b00, 10'h101, 32'h0000_00A1);
    for (int n = 0; n < 4; n++) sb.push_back('{(n % 2 == 0) ? 2'b01 : 2'b10, 1'b0, exp_rd, (n % 2 == 0) ? 10'h100 : 10'h101});
    for (int n = 0; n < 4; n++) begin
      wait_done(lat, msel_lo, req_hi, idle);
      check("b2b_latency", 64'(lat), (n == 0) ? 64'd2 : 64'd3);
      check("b2b_idle",    64'(idle), (n == 0) ? 64'd0 : 64'd1);
    end
    bus.req_i = '0;
    @(negedge clk);

    // MDIO read: stale ready in the request cycle, five low cycles, then data.
    phy_stuck = 1'b0;
    phy_delay = 5;
    phy_data  = 32'h0000_796D;
    exp_rd    = 32'h0000_796D;
    sb.push_back('{2'b01, 1'b0, exp_rd, 10'h01E});
    drive(0, 1'b1, 2'b10, 10'h01E, 32'h0);
    wait_done(lat, msel_lo, req_hi, idle);
    bus.req_i = '0;
    check("mdio_latency",    64'(lat), 64'd8);
    check("mdio_hostreq",    64'(req_hi), 64'd1);
    check("mdio_miimsel_lo", 64'(msel_lo), 64'd0);
    @(negedge clk);

    // MDIO timeout: ready stuck low, 4-bit counter.
    phy_stuck = 1'b1;
    exp_rd    = 32'hFFFF_FFFF;
    sb.push_back('{2'b01, 1'b1, exp_rd, 10'h011});
    drive(0, 1'b1, 2'b10, 10'h011, 32'h0);
    wait_done(lat, msel_lo, req_hi, idle);
    bus.req_i = '0;
    check("timeout_latency", 64'(lat), 64'(1 + 15));
    @(negedge clk);

    // Following MDIO op completes normally.
    phy_stuck = 1'b0;
    phy_delay = 0;
    phy_data  = 32'h0000_1357;
    exp_rd    = 32'h0000_1357;
    sb.push_back('{2'b01, 1'b0, exp_rd, 10'h012});
    drive(0, 1'b1, 2'b00, 10'h012, 32'h0);
    wait_done(lat, msel_lo, req_hi, idle);
    bus.req_i = '0;
    check("mdio2_latency", 64'(lat), 64'd3);
    @(negedge clk);

    // Asynchronous reset in the hostreq cycle of an MDIO op from requester 1.
    phy_stuck = 1'b1;
    drive(1, 1'b1, 2'b10, 10'h022, 32'h0);
    @(posedge clk);
    #2;
    check("pre_rst_hostreq", 64'(bus.hostreq), 64'd1);
    check("pre_rst_busy",    64'(bus.busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_hostreq",     64'(bus.hostreq), 64'd0);
    check("rst_mid_busy",        64'(bus.busy_o), 64'd0);
    check("rst_mid_done",        64'(bus.done_o), 64'd0);
    check("rst_mid_hostmiimsel", 64'(bus.hostmiimsel), 64'd1);
    bus.req_i = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    phy_stuck = 1'b0;
    exp_rd = '0;
    @(negedge clk);

    // After reset requester 0 wins even though 1 also requests.
    sb.push_back('{2'b01, 1'b0, exp_rd, 10'h033});
    drive(0, 1'b0, 2'b00, 10'h033, 32'h0000_0055);
    drive(1, 1'b0, 2'b00, 10'h044, 32'h0000_0066);
    wait_done(lat, msel_lo, req_hi, idle);
    bus.req_i = '0;
    check("post_rst_wrdata", 64'(bus.hostwrdata), 64'h55);
    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
